// File: rtl/light_pack.sv
// Shared types for the ray/triangle pipeline: fixed-point scalars, geometry
// payloads, intersection result codes and the hit-scheduler state encoding.
package light_pack;

    localparam int unsigned FIXED_WIDTH = 16;
    localparam int unsigned FRAC_BITS   = 8;
    localparam int unsigned WIDE_WIDTH  = 64;

    typedef logic signed [FIXED_WIDTH-1:0] fixed;

    localparam fixed FIXED_MAX = {1'b0, {(FIXED_WIDTH-1){1'b1}}};
    localparam fixed FIXED_MIN = {1'b1, {(FIXED_WIDTH-1){1'b0}}};

    typedef struct packed {
        fixed x;
        fixed y;
        fixed z;
    } vec3;

    typedef struct packed {
        vec3 origin;
        vec3 dir;
    } ray;

    typedef struct packed {
        vec3 v0;
        vec3 v1;
        vec3 v2;
    } triangle;

    localparam logic [1:0] CODE_MISS     = 2'b00;
    localparam logic [1:0] CODE_HIT      = 2'b01;
    localparam logic [1:0] CODE_PARALLEL = 2'b10;
    localparam logic [1:0] CODE_DEGEN    = 2'b11;

    typedef enum logic [2:0] {
        SCHED_IDLE,
        SCHED_READ,
        SCHED_LOAD,
        SCHED_EVAL,
        SCHED_DONE
    } sched_state_t;

endpackage

// File: rtl/intersectionTest.sv
// Combinational ray/triangle intersection (Moller-Trumbore) on fixed-point
// operands; reports a result code and the saturated hit distance t.
module intersectionTest
    import light_pack::*;
(
    input  ray         ray_vec,
    input  triangle    trig,
    input  fixed       of,
    output logic [1:0] code,
    output fixed       t
);

    typedef logic signed [WIDE_WIDTH-1:0] wide_t;

    function automatic wide_t wx(input fixed a);
        return wide_t'(a);
    endfunction

    wide_t e1x, e1y, e1z, e2x, e2y, e2z;
    wide_t dx, dy, dz, tx, ty, tz;
    wide_t px, py, pz, qx, qy, qz, nx, ny, nz;
    wide_t det, u_num, v_num, t_num;
    wide_t det_a, u_a, v_a, t_a, quot, t_full;

    assign e1x = wx(trig.v1.x) - wx(trig.v0.x);
    assign e1y = wx(trig.v1.y) - wx(trig.v0.y);
    assign e1z = wx(trig.v1.z) - wx(trig.v0.z);
    assign e2x = wx(trig.v2.x) - wx(trig.v0.x);
    assign e2y = wx(trig.v2.y) - wx(trig.v0.y);
    assign e2z = wx(trig.v2.z) - wx(trig.v0.z);

    assign dx = wx(ray_vec.dir.x);
    assign dy = wx(ray_vec.dir.y);
    assign dz = wx(ray_vec.dir.z);
    assign tx = wx(ray_vec.origin.x) - wx(trig.v0.x);
    assign ty = wx(ray_vec.origin.y) - wx(trig.v0.y);
    assign tz = wx(ray_vec.origin.z) - wx(trig.v0.z);

    // p = dir x e2, q = tvec x e1, n = e1 x e2 (zero area => degenerate)
    assign px = dy * e2z - dz * e2y;
    assign py = dz * e2x - dx * e2z;
    assign pz = dx * e2y - dy * e2x;
    assign qx = ty * e1z - tz * e1y;
    assign qy = tz * e1x - tx * e1z;
    assign qz = tx * e1y - ty * e1x;
    assign nx = e1y * e2z - e1z * e2y;
    assign ny = e1z * e2x - e1x * e2z;
    assign nz = e1x * e2y - e1y * e2x;

    assign det   = e1x * px + e1y * py + e1z * pz;
    assign u_num = tx * px + ty * py + tz * pz;
    assign v_num = dx * qx + dy * qy + dz * qz;
    assign t_num = e2x * qx + e2y * qy + e2z * qz;

    // Normalise to a positive determinant so barycentric tests need no sign logic
    assign det_a = (det < 0) ? -det   : det;
    assign u_a   = (det < 0) ? -u_num : u_num;
    assign v_a   = (det < 0) ? -v_num : v_num;
    assign t_a   = (det < 0) ? -t_num : t_num;

    assign quot   = (det == '0) ? '0 : (t_a <<< FRAC_BITS) / det_a;
    assign t_full = quot + wx(of);

    always_comb begin
        code = CODE_MISS;
        if (nx == '0 && ny == '0 && nz == '0) begin
            code = CODE_DEGEN;
        end else if (det == '0) begin
            code = CODE_PARALLEL;
        end else if (u_a >= 0 && v_a >= 0 && (u_a + v_a) <= det_a) begin
            code = CODE_HIT;
        end
    end

    always_comb begin
        t = fixed'(t_full);
        if (t_full > wx(FIXED_MAX)) begin
            t = FIXED_MAX;
        end else if (t_full < wx(FIXED_MIN)) begin
            t = FIXED_MIN;
        end
    end

endmodule

// File: rtl/triangle_hit_scheduler.sv
// Walks a triangle list for one ray through a single shared intersection test
// (read, load, evaluate per triangle) and reports the closest accepted hit.
module triangle_hit_scheduler
    import light_pack::*;
#(
    parameter int unsigned MAX_TRIS = 1024,
    parameter int unsigned IDX_W    = $clog2(MAX_TRIS),
    parameter fixed        OF       = '0,
    parameter fixed        T_MIN    = fixed'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  ray               ray_in,
    input  logic [IDX_W-1:0] tri_base,
    input  logic [IDX_W:0]   tri_count,
    output logic             busy,
    output logic [IDX_W-1:0] mem_addr,
    output logic             mem_rd,
    input  triangle          mem_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_hit,
    output fixed             res_t,
    output logic [IDX_W-1:0] res_idx
);

    localparam int unsigned CNT_W = IDX_W + 1;

    sched_state_t     state;
    ray               ray_q;
    triangle          trig_q;
    logic [IDX_W-1:0] base_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] i_q;
    logic             best_hit;
    fixed             best_t;
    logic [IDX_W-1:0] best_idx;

    logic [1:0]       isect_code;
    fixed             isect_t;
    logic             take;
    logic             last;

    intersectionTest u_isect (
        .ray_vec (ray_q),
        .trig    (trig_q),
        .of      (OF),
        .code    (isect_code),
        .t       (isect_t)
    );

    // Strict less-than keeps the lower index on equal distances
    assign take = (isect_code == CODE_HIT) && (isect_t >= T_MIN) && (isect_t < best_t);
    // count_q is at least 1 whenever EVAL is reached, so this cannot wrap
    assign last = (i_q == count_q - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SCHED_IDLE;
            ray_q     <= '0;
            trig_q    <= '0;
            base_q    <= '0;
            count_q   <= '0;
            i_q       <= '0;
            best_hit  <= 1'b0;
            best_t    <= FIXED_MAX;
            best_idx  <= '0;
            busy      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            res_valid <= 1'b0;
            res_hit   <= 1'b0;
            res_t     <= FIXED_MAX;
            res_idx   <= '0;
        end else begin
            case (state)
                SCHED_IDLE: begin
                    if (start) begin
                        ray_q    <= ray_in;
                        base_q   <= tri_base;
                        count_q  <= tri_count;
                        i_q      <= '0;
                        best_hit <= 1'b0;
                        best_t   <= FIXED_MAX;
                        best_idx <= '0;
                        busy     <= 1'b1;
                        if (tri_count == '0) begin
                            state     <= SCHED_DONE;
                            res_valid <= 1'b1;
                            res_hit   <= 1'b0;
                            res_t     <= FIXED_MAX;
                            res_idx   <= '0;
                        end else begin
                            state    <= SCHED_READ;
                            mem_rd   <= 1'b1;
                            mem_addr <= tri_base;
                        end
                    end
                end

                SCHED_READ: begin
                    mem_rd <= 1'b0;
                    state  <= SCHED_LOAD;
                end

                SCHED_LOAD: begin
                    trig_q <= mem_data;
                    state  <= SCHED_EVAL;
                end

                SCHED_EVAL: begin
                    if (take) begin
                        best_hit <= 1'b1;
                        best_t   <= isect_t;
                        best_idx <= i_q[IDX_W-1:0];
                    end
                    if (last) begin
                        state     <= SCHED_DONE;
                        res_valid <= 1'b1;
                        res_hit   <= take | best_hit;
                        res_t     <= take ? isect_t : best_t;
                        res_idx   <= take ? i_q[IDX_W-1:0] : best_idx;
                    end else begin
                        state    <= SCHED_READ;
                        i_q      <= i_q + CNT_W'(1);
                        mem_rd   <= 1'b1;
                        mem_addr <= base_q + i_q[IDX_W-1:0] + IDX_W'(1);
                    end
                end

                SCHED_DONE: begin
                    if (res_ready) begin
                        state     <= SCHED_IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: state <= SCHED_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_triangle_hit_scheduler.sv
// Scoreboard bench for triangle_hit_scheduler: triangles are built so their
// intersection outcome is known by construction; a reference picks the winner.
`timescale 1ns/1ps
module tb_triangle_hit_scheduler;
    import light_pack::*;

    localparam int MAX_TRIS = 1024;
    localparam int IDX_W    = 10;
    localparam int K_HIT    = 0;
    localparam int K_MISS   = 1;
    localparam int K_PAR    = 2;
    localparam int K_DEGEN  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    ray               ray_in;
    logic [IDX_W-1:0] tri_base;
    logic [IDX_W:0]   tri_count;
    logic             busy;
    logic [IDX_W-1:0] mem_addr;
    logic             mem_rd;
    triangle          mem_data;
    logic             res_valid;
    logic             res_ready;
    logic             res_hit;
    fixed             res_t;
    logic [IDX_W-1:0] res_idx;

    triangle_hit_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ray_in    (ray_in),
        .tri_base  (tri_base),
        .tri_count (tri_count),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_hit   (res_hit),
        .res_t     (res_t),
        .res_idx   (res_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hit;
        int t;
        int idx;
        int lat;
    } exp_t;

    exp_t    exp_q[$];
    int      exp_addr_q[$];
    triangle mem [MAX_TRIS];
    int      job_kind [MAX_TRIS];
    int      job_t    [MAX_TRIS];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    int      accept_cyc = 0;
    bit      in_res = 0;
    exp_t    cur;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-cycle-latency triangle RAM
    always @(posedge clk) if (mem_rd === 1'b1) mem_data <= mem[mem_addr];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Read-address scoreboard
    always @(negedge clk) begin
        if (mem_rd === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read addr %0d (cycle %0d)", mem_addr, cyc);
            end else begin
                check("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
        end
    end

    // Result monitor: pops on the first valid cycle, then checks the result holds
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            in_res = 0;
        end else if (res_valid === 1'b1) begin
            if (!in_res) begin
                in_res = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result hit %0d t %0d idx %0d (cycle %0d)",
                             res_hit, res_t, res_idx, cyc);
                    cur = '{hit: res_hit, t: int'(res_t), idx: int'(res_idx), lat: 0};
                end else begin
                    cur = exp_q.pop_front();
                    check("res_hit", res_hit, cur.hit);
                    check("res_t", res_t, cur.t);
                    check("res_idx", res_idx, cur.idx);
                    check("latency", cyc - accept_cyc, cur.lat);
                end
            end else begin
                check("hold_res_hit", res_hit, cur.hit);
                check("hold_res_t", res_t, cur.t);
                check("hold_res_idx", res_idx, cur.idx);
            end
        end else begin
            in_res = 0;
        end
    end

    function automatic vec3 mk(input int x, input int y, input int z);
        vec3 v;
        v.x = fixed'(x);
        v.y = fixed'(y);
        v.z = fixed'(z);
        return v;
    endfunction

    // Triangle geometry for a ray along +z; a HIT triangle has its centroid at origin + t*dir
    function automatic triangle make_tri(input int kind, input int t, input int ox,
                                         input int oy, input int oz, input int s);
        triangle tr;
        int pz;
        pz = oz + t;
        case (kind)
            K_HIT: begin
                tr.v0 = mk(ox - s, oy - s, pz);
                tr.v1 = mk(ox + 2*s, oy - s, pz);
                tr.v2 = mk(ox - s, oy + 2*s, pz);
            end
            K_MISS: begin
                tr.v0 = mk(ox + 9*s, oy - s, pz);
                tr.v1 = mk(ox + 12*s, oy - s, pz);
                tr.v2 = mk(ox + 9*s, oy + 2*s, pz);
            end
            K_PAR: begin
                tr.v0 = mk(ox, oy, pz);
                tr.v1 = mk(ox + s, oy, pz);
                tr.v2 = mk(ox, oy, pz + s);
            end
            default: begin
                tr.v0 = mk(ox, oy, pz);
                tr.v1 = mk(ox, oy, pz);
                tr.v2 = mk(ox, oy, pz);
            end
        endcase
        return tr;
    endfunction

    task automatic set_tri(input int k, input int kind, input int t);
        job_kind[k] = kind;
        job_t[k]    = t;
    endtask

    task automatic rand_tri(input int k);
        int r;
        int t;
        r = int'($urandom_range(0, 9));
        t = int'($urandom_range(0, 6500)) - 500;
        if (r < 5) begin
            case ($urandom_range(0, 4))
                0: t = int'($urandom_range(0, 1));
                1: t = 768;
                default: ;
            endcase
            set_tri(k, K_HIT, t);
        end else if (r < 7) begin
            set_tri(k, K_MISS, t);
        end else if (r < 9) begin
            set_tri(k, K_PAR, t);
        end else begin
            set_tri(k, K_DEGEN, t);
        end
    endtask

    task automatic run_job(input int n, input int base, input int hold, input bit abort);
        int   ox;
        int   oy;
        int   oz;
        int   addr;
        bit   got;
        exp_t e;
        ox = int'($urandom_range(0, 2000)) - 1000;
        oy = int'($urandom_range(0, 2000)) - 1000;
        oz = int'($urandom_range(0, 2000)) - 1000;
        e = '{hit: 0, t: 32767, idx: 0, lat: (n == 0) ? 1 : 3*n + 1};
        for (int k = 0; k < n; k++) begin
            addr = (base + k) % MAX_TRIS;
            mem[addr] = make_tri(job_kind[k], job_t[k], ox, oy, oz, int'($urandom_range(4, 64)));
            if (!abort || k == 0) exp_addr_q.push_back(addr);
            // Closest accepted distance; the first index wins a tie
            if (job_kind[k] == K_HIT && job_t[k] >= 1 && job_t[k] < e.t) begin
                e.hit = 1;
                e.t   = job_t[k];
                e.idx = k;
            end
        end
        if (!abort) exp_q.push_back(e);

        ray_in    = '{origin: mk(ox, oy, oz), dir: mk(0, 0, 256)};
        tri_base  = IDX_W'(base);
        tri_count = (IDX_W+1)'(n);
        start     = 1'b1;
        accept_cyc = cyc;
        @(negedge clk);
        check("busy_accept_cycle", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;

        if (abort) begin
            check("mem_rd_in_read", mem_rd, 1);
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(negedge clk);
            check("abort_busy", busy, 0);
            check("abort_res_valid", res_valid, 0);
            check("abort_mem_rd", mem_rd, 0);
            check("abort_res_hit", res_hit, 0);
            check("abort_res_t", res_t, 32767);
            check("abort_res_idx", res_idx, 0);
            check("abort_mem_addr", mem_addr, 0);
            repeat (20) @(posedge clk);
            #1;
            return;
        end

        @(negedge clk);
        check("busy_after_accept", busy, 1);
        got = 0;
        for (int c = 0; c < 3*n + 10 && !got; c++) begin
            @(posedge clk); #1;
            got = (res_valid === 1'b1);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL res_valid_timeout n %0d (cycle %0d)", n, cyc);
            exp_q.delete();
            exp_addr_q.delete();
        end
        res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start     = 1'b1;
            tri_count = (IDX_W+1)'(3);
            tri_base  = IDX_W'($urandom_range(0, MAX_TRIS - 1));
            @(posedge clk); #1;
        end
        start     = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("busy_after_consume", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        res_ready = 1'b0;
        ray_in    = '0;
        tri_base  = '0;
        tri_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_mem_rd", mem_rd, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_res_hit", res_hit, 0);
        check("reset_res_t", res_t, 32767);
        check("reset_res_idx", res_idx, 0);
        check("reset_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty list
        run_job(0, int'($urandom_range(0, MAX_TRIS - 1)), 0, 0);

        // Hits at 5.0 (idx 1) and 2.0 (idx 3)
        set_tri(0, K_MISS, 300);  set_tri(1, K_HIT, 1280);
        set_tri(2, K_MISS, 700);  set_tri(3, K_HIT, 512);
        run_job(4, int'($urandom_range(0, MAX_TRIS - 1)), 0, 0);

        // Tie at 3.0 resolves to the lower index
        set_tri(0, K_HIT, 768);   set_tri(1, K_MISS, 100);
        set_tri(2, K_HIT, 768);   set_tri(3, K_PAR, 200);
        run_job(4, int'($urandom_range(0, MAX_TRIS - 1)), 0, 0);

        // Only rejected candidates
        set_tri(0, K_HIT, 0);     set_tri(1, K_PAR, 400);
        set_tri(2, K_PAR, 900);   set_tri(3, K_HIT, -300);
        set_tri(4, K_DEGEN, 600);
        run_job(5, int'($urandom_range(0, MAX_TRIS - 1)), 1, 0);

        // Smallest accepted distance
        set_tri(0, K_PAR, 10);    set_tri(1, K_HIT, 1);    set_tri(2, K_HIT, 1);
        run_job(3, int'($urandom_range(0, MAX_TRIS - 1)), 0, 0);

        // Address wrap at the top of the RAM
        set_tri(0, K_HIT, 100);   set_tri(1, K_HIT, 50);
        run_job(2, MAX_TRIS - 1, 0, 0);

        for (int j = 0; j < 14; j++) begin
            n = int'($urandom_range(1, 12));
            for (int k = 0; k < n; k++) rand_tri(k);
            run_job(n, int'($urandom_range(0, MAX_TRIS - 1)), int'($urandom_range(0, 2)), 0);
        end

        // Full-capacity list
        for (int k = 0; k < MAX_TRIS; k++) rand_tri(k);
        run_job(MAX_TRIS, int'($urandom_range(0, MAX_TRIS - 1)), 0, 0);

        // Back-pressure with stray start pulses, then reset during a read
        set_tri(0, K_HIT, 2000);  set_tri(1, K_HIT, 900);  set_tri(2, K_MISS, 5);
        run_job(3, int'($urandom_range(0, MAX_TRIS - 1)), 5, 0);
        for (int k = 0; k < 4; k++) rand_tri(k);
        run_job(4, int'($urandom_range(0, MAX_TRIS - 1)), 0, 1);

        // Recovery after the aborted job
        for (int k = 0; k < 3; k++) rand_tri(k);
        run_job(3, int'($urandom_range(0, MAX_TRIS - 1)), 0, 0);

        repeat (5) @(posedge clk);
        #1;
        check("results_outstanding", exp_q.size(), 0);
        check("reads_outstanding", exp_addr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
